// File: rtl/stack_op_controller_if.sv
// Decode/memory-side bundle of the stack sequencer: op request in, stack access strobes, SP and fault out.
// The controller binds to slave; the decode/memory side binds to master.
interface stack_op_controller_if;
    logic        Enable;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  wdata_sel;
    logic [1:0]  rdata_dst;
    logic [31:0] sp_out;
    logic        fault;

    modport master (
        output Enable, op_valid, op_code,
        input  busy, done, mem_addr, mem_we, mem_re, wdata_sel, rdata_dst, sp_out, fault
    );

    modport slave (
        input  Enable, op_valid, op_code,
        output busy, done, mem_addr, mem_we, mem_re, wdata_sel, rdata_dst, sp_out, fault
    );
endinterface

// File: rtl/stack_op_controller.sv
// Stack sequencer: turns PUSH/POP/CALL/RET/INT/RTI into 1-2 ordered stack accesses and owns SP (full-descending).
// Latency 2 cycles from accept (3 for INT/RTI); Enable=0 freezes everything. Optional macro STACK_BOUND_CHECK_EN.
module stack_op_controller #(
    parameter logic [31:0] STACK_BASE  = 32'h000F_FFFF,
    parameter logic [31:0] STACK_LIMIT = 32'h000F_F000
) (
    input  logic                  CLK,
    input  logic                  Reset,
    stack_op_controller_if.slave  bus
);
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_INT  = 3'b101;
    localparam logic [2:0] OP_RTI  = 3'b110;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

    state_t      state, nextState;
    logic [31:0] spReg, nextSp;
    logic [2:0]  opReg;
    logic        opPush;
    logic        opLegal;
    logic        accept;
    logic [31:0] memAddr;
    logic        memWe, memRe, doneC;
    logic [1:0]  wSel, rDst;

    assign opLegal = (bus.op_code != 3'b000) && (bus.op_code != 3'b111);
    assign opPush  = (opReg == OP_PUSH) || (opReg == OP_CALL) || (opReg == OP_INT);

`ifdef STACK_BOUND_CHECK_EN
    logic        reqPush, reject, rejectHit, faultReg;
    logic [32:0] reqSlots, spWide;

    // 33-bit compares so the free-slot arithmetic never wraps.
    assign reqPush  = (bus.op_code == OP_PUSH) || (bus.op_code == OP_CALL) || (bus.op_code == OP_INT);
    assign reqSlots = ((bus.op_code == OP_INT) || (bus.op_code == OP_RTI)) ? 33'd2 : 33'd1;
    assign spWide   = {1'b0, spReg};
    assign reject   = reqPush ? ((spWide + 33'd1) < ({1'b0, STACK_LIMIT} + reqSlots))
                              : ((spWide + reqSlots) > {1'b0, STACK_BASE});
    assign rejectHit = (state == IDLE) && bus.Enable && bus.op_valid && opLegal && reject;
    assign accept    = (state == IDLE) && bus.Enable && bus.op_valid && opLegal && !reject;

    always_ff @(posedge CLK) begin
        if (Reset) faultReg <= 1'b0;
        else       faultReg <= rejectHit;
    end
    assign bus.fault = faultReg;
`else
    assign accept    = (state == IDLE) && bus.Enable && bus.op_valid && opLegal;
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        nextState = state;
        nextSp    = spReg;
        memAddr   = 32'd0;
        memWe     = 1'b0;
        memRe     = 1'b0;
        wSel      = 2'd0;
        rDst      = 2'd0;
        doneC     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) nextState = ACC1;
            end
            ACC1: begin
                if (opPush) begin
                    memAddr = spReg;
                    memWe   = bus.Enable;
                    wSel    = (opReg == OP_PUSH) ? 2'd0 : 2'd1;
                end else begin
                    memAddr = spReg + 32'd1;
                    memRe   = bus.Enable;
                    rDst    = (opReg == OP_POP) ? 2'd0 : ((opReg == OP_RET) ? 2'd1 : 2'd2);
                end
                if (bus.Enable) begin
                    nextSp = opPush ? (spReg - 32'd1) : (spReg + 32'd1);
                    if ((opReg == OP_INT) || (opReg == OP_RTI)) begin
                        nextState = ACC2;
                    end else begin
                        nextState = IDLE;
                        doneC     = 1'b1;
                    end
                end
            end
            ACC2: begin
                // Second half of INT (FLAGS below PC) or RTI (PC after FLAGS).
                if (opPush) begin
                    memAddr = spReg;
                    memWe   = bus.Enable;
                    wSel    = 2'd2;
                end else begin
                    memAddr = spReg + 32'd1;
                    memRe   = bus.Enable;
                    rDst    = 2'd1;
                end
                if (bus.Enable) begin
                    nextSp    = opPush ? (spReg - 32'd1) : (spReg + 32'd1);
                    nextState = IDLE;
                    doneC     = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            spReg <= STACK_BASE;
            opReg <= 3'b000;
        end else begin
            state <= nextState;
            spReg <= nextSp;
            if (accept) opReg <= bus.op_code;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = doneC;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_we    = memWe;
    assign bus.mem_re    = memRe;
    assign bus.wdata_sel = wSel;
    assign bus.rdata_dst = rDst;
    assign bus.sp_out    = spReg;
endmodule

// File: tb/tb_stack_op_controller.sv
// Directed vector bench for stack_op_controller; build with +define+STACK_BOUND_CHECK_EN to cover the bound check.
module tb_stack_op_controller;
    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    stack_op_controller_if bus ();

    stack_op_controller dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] B = 32'h000F_FFFF;

    typedef struct {
        logic        rst, en, vld;
        logic [2:0]  op;
        logic        busy, done, we, re;
        logic [31:0] addr;
        logic [1:0]  wsel, rdst;
        logic [31:0] sp;
        logic        fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic vld, input logic [2:0] op,
                       input logic busy, input logic done, input logic we, input logic re,
                       input logic [31:0] addr, input logic [1:0] wsel, input logic [1:0] rdst,
                       input logic [31:0] sp, input logic fault);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.op = op;
        v.busy = busy; v.done = done; v.we = we; v.re = re;
        v.addr = addr; v.wsel = wsel; v.rdst = rdst; v.sp = sp; v.fault = fault;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic en, input logic vld, input logic [2:0] op);
        Reset = rst; bus.Enable = en; bus.op_valid = vld; bus.op_code = op;
    endtask

    task automatic check(input string name, input vec_t e);
        checks++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.mem_we !== e.we || bus.mem_re !== e.re ||
            bus.mem_addr !== e.addr || bus.wdata_sel !== e.wsel || bus.rdata_dst !== e.rdst ||
            bus.sp_out !== e.sp || bus.fault !== e.fault) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b we=%b re=%b addr=%h wsel=%0d rdst=%0d sp=%h fault=%b ; want busy=%b done=%b we=%b re=%b addr=%h wsel=%0d rdst=%0d sp=%h fault=%b",
                     name, bus.busy, bus.done, bus.mem_we, bus.mem_re, bus.mem_addr, bus.wdata_sel,
                     bus.rdata_dst, bus.sp_out, bus.fault, e.busy, e.done, e.we, e.re, e.addr,
                     e.wsel, e.rdst, e.sp, e.fault);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        int doneCount;
        drive(1'b1, 1'b0, 1'b0, 3'b000);
        repeat (2) @(posedge CLK);

        //  rst en vld op      busy done we re addr          wsel rdst sp            fault
        add(1, 0, 0, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // reset state
        add(0, 1, 1, 3'b001,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // accept PUSH
        add(0, 1, 0, 3'b000,  1, 1, 1, 0, B,              0, 0, B,             0); // PUSH access
        add(0, 1, 1, 3'b010,  0, 0, 0, 0, 32'd0,          0, 0, 32'h000F_FFFE, 0); // accept POP
        add(0, 1, 0, 3'b000,  1, 1, 0, 1, B,              0, 0, 32'h000F_FFFE, 0); // POP access
        add(0, 1, 1, 3'b101,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // accept INT
        add(0, 1, 0, 3'b000,  1, 0, 1, 0, B,              1, 0, B,             0); // INT ACC1 PC
        add(0, 1, 1, 3'b110,  1, 1, 1, 0, 32'h000F_FFFE, 2, 0, 32'h000F_FFFE, 0); // INT ACC2 FLAGS, op ignored
        add(0, 1, 1, 3'b110,  0, 0, 0, 0, 32'd0,          0, 0, 32'h000F_FFFD, 0); // accept RTI
        add(0, 1, 0, 3'b000,  1, 0, 0, 1, 32'h000F_FFFE, 0, 2, 32'h000F_FFFD, 0); // RTI FLAGS
        add(0, 1, 0, 3'b000,  1, 1, 0, 1, B,              0, 1, 32'h000F_FFFE, 0); // RTI PC
        add(0, 1, 1, 3'b111,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // illegal 111
        add(0, 1, 1, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // illegal 000 ignored
        add(0, 0, 1, 3'b011,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // CALL with Enable=0
        add(0, 1, 1, 3'b011,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // accept CALL
        add(0, 1, 1, 3'b100,  1, 1, 1, 0, B,              1, 0, B,             0); // CALL access
        add(0, 1, 1, 3'b100,  0, 0, 0, 0, 32'd0,          0, 0, 32'h000F_FFFE, 0); // accept RET
        add(0, 1, 0, 3'b000,  1, 1, 0, 1, B,              0, 1, 32'h000F_FFFE, 0); // RET access
        add(0, 1, 1, 3'b101,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // accept INT
        add(0, 0, 0, 3'b000,  1, 0, 0, 0, B,              1, 0, B,             0); // stall 1
        add(0, 0, 0, 3'b000,  1, 0, 0, 0, B,              1, 0, B,             0); // stall 2
        add(0, 0, 0, 3'b000,  1, 0, 0, 0, B,              1, 0, B,             0); // stall 3
        add(0, 1, 0, 3'b000,  1, 0, 1, 0, B,              1, 0, B,             0); // ACC1 reissued
        add(0, 1, 0, 3'b000,  1, 1, 1, 0, 32'h000F_FFFE, 2, 0, 32'h000F_FFFE, 0); // ACC2
        add(0, 1, 1, 3'b101,  0, 0, 0, 0, 32'd0,          0, 0, 32'h000F_FFFD, 0); // second INT
        add(0, 1, 0, 3'b000,  1, 0, 1, 0, 32'h000F_FFFD, 1, 0, 32'h000F_FFFD, 0); // ACC1
        add(1, 1, 0, 3'b000,  1, 1, 1, 0, 32'h000F_FFFC, 2, 0, 32'h000F_FFFC, 0); // Reset in ACC2
        add(0, 1, 0, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // aborted
        add(0, 1, 1, 3'b010,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // POP at empty
`ifdef STACK_BOUND_CHECK_EN
        add(0, 1, 0, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, B,             1); // rejected, fault
        add(0, 1, 0, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, B,             0); // fault one cycle
`else
        add(0, 1, 0, 3'b000,  1, 1, 0, 1, 32'h0010_0000, 0, 0, B,             0); // wrapping read
        add(0, 1, 0, 3'b000,  0, 0, 0, 0, 32'd0,          0, 0, 32'h0010_0000, 0); // SP past base
`endif

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].op);
            #1;
            check($sformatf("vec%0d", i), vecs[i]);
        end

        // PUSH with a 2-cycle stall must produce exactly one done and one net SP step.
        @(negedge CLK); drive(1'b1, 1'b0, 1'b0, 3'b000);
        @(negedge CLK); drive(1'b0, 1'b1, 1'b1, 3'b001);
        doneCount = 0;
        @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 3'b000);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.done === 1'b1) doneCount++;
            @(negedge CLK);
            drive(1'b0, (c >= 1) ? 1'b1 : 1'b0, 1'b0, 3'b000);
        end
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("FAIL stall_done_count: got %0d want 1", doneCount);
        end
        #1;
        checkWord("stall_sp", bus.sp_out, 32'h000F_FFFE);

`ifdef STACK_BOUND_CHECK_EN
        // Fill down to the limit, then INT needs two slots but only one is free.
        @(negedge CLK); drive(1'b1, 1'b0, 1'b0, 3'b000);
        for (int k = 0; k < 32'h0000_0FFF; k++) begin
            @(negedge CLK); drive(1'b0, 1'b1, 1'b1, 3'b001);
            @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 3'b000);
        end
        @(negedge CLK); drive(1'b0, 1'b1, 1'b1, 3'b101);
        #1;
        checkWord("fill_sp", bus.sp_out, 32'h000F_F000);
        @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        checkBit("int_full_fault", bus.fault, 1'b1);
        checkBit("int_full_busy", bus.busy, 1'b0);
        checkBit("int_full_we", bus.mem_we, 1'b0);
        @(negedge CLK);
        #1;
        checkBit("int_full_fault_clear", bus.fault, 1'b0);
        checkWord("int_full_sp", bus.sp_out, 32'h000F_F000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_op_controller.md
Name: stack_op_controller

Overview:
- Sequences all stack traffic for the RISC core: PUSH, POP, CALL, RET, INT and RTI.
- Converts each decoded stack operation into one or two ordered memory accesses and owns the architectural stack pointer (SP).
- Sits between decode and the data-memory stage. Stalls the front end via busy while a multi-access sequence is in flight.

Parameters:
- STACK_BASE, 32'h000F_FFFF, SP reset value; the stack is empty when SP equals this value.
- STACK_LIMIT, 32'h000F_F000, lowest address a push may write; the stack is full when SP is below this value.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  pipeline enable; when 0, all state and SP hold, and mem_we/mem_re are forced to 0.
- op_valid  input  1  a stack operation is presented this cycle.
- op_code  input  3  001 PUSH, 010 POP, 011 CALL, 100 RET, 101 INT, 110 RTI; 000 and 111 are ignored.
- busy  output  1  controller is not IDLE; decode must hold.
- done  output  1  one-cycle pulse on the final access of an operation.
- mem_addr  output  32  stack memory address for the current access.
- mem_we  output  1  stack write strobe.
- mem_re  output  1  stack read strobe.
- wdata_sel  output  2  write source: 0 register, 1 PC, 2 FLAGS.
- rdata_dst  output  2  read destination: 0 register, 1 PC, 2 FLAGS.
- sp_out  output  32  current SP, as a registered value.
- fault  output  1  one-cycle pulse when an operation is rejected by the bound check.

Behaviour:
- Reset state: SP=STACK_BASE, state IDLE; busy, done, mem_we, mem_re and fault are 0; mem_addr, wdata_sel and rdata_dst are 0. Reset asserted mid-sequence aborts the sequence with no further accesses.
- Convention: full-descending stack, SP points at the next free slot.
  - Push: mem_addr=SP, then SP<=SP-1.
  - Pop: mem_addr=SP+1, then SP<=SP+1.
- States: IDLE, ACC1, ACC2.
- Accept: in IDLE with Enable=1, op_valid=1 and a legal op_code, the op is latched and the state moves to ACC1 on the next edge. busy rises in the cycle after accept.
- While busy=1, op_valid is ignored.
- ACC1 (first access):
  - PUSH: write, wdata_sel=0.
  - POP: read, rdata_dst=0.
  - CALL: write, wdata_sel=1.
  - RET: read, rdata_dst=1.
  - INT: write, wdata_sel=1.
  - RTI: read, rdata_dst=2.
  - For single-access ops: done=1, then go to IDLE. For INT/RTI: go to ACC2.
- ACC2 (second access), with done=1, then go to IDLE:
  - INT: write, wdata_sel=2.
  - RTI: read, rdata_dst=1.
- Ordering: INT pushes PC and then FLAGS; RTI pops FLAGS and then PC, so the pair is restored in LIFO order.
- Latency: single-access ops complete in 2 cycles from accept, INT/RTI in 3. Back-to-back ops: a new op may be accepted in the cycle busy falls.
- SP arithmetic is 32-bit unsigned. SP updates on the edge that ends each access cycle.
- Enable=0 during ACC1 or ACC2: the access repeats, with identical mem_addr and selects, once Enable returns to 1. No SP update and no done occur while Enable=0.
- An illegal op_code (000 or 111) with op_valid=1 produces no state change and no fault.

Optional Feature:
- STACK_BOUND_CHECK_EN defined:
  - The check runs at accept time for the whole operation.
  - A push sequence needing n slots is rejected if SP-n < STACK_LIMIT-1, i.e. fewer than n free slots.
  - A pop sequence needing n slots is rejected if STACK_BASE-SP < n.
  - On reject: state stays IDLE, SP is unchanged, no memory access occurs, and fault pulses high on the cycle after op_valid.
- STACK_BOUND_CHECK_EN undefined: no check is performed; SP wraps modulo 2^32 and fault is tied to 0.

Test Plan:
- Reset, then PUSH accepted -> next cycle mem_addr=32'h000F_FFFF, mem_we=1, wdata_sel=0, done=1; the following cycle sp_out=32'h000F_FFFE and busy=0.
- PUSH then POP back-to-back -> POP access has mem_addr=32'h000F_FFFF, mem_re=1, rdata_dst=0; sp_out returns to 32'h000F_FFFF.
- INT from SP=32'h000F_FFFF -> ACC1 write at ...FFFF with wdata_sel=1; ACC2 write at ...FFFE with wdata_sel=2, done=1; final sp_out=...FFFD; busy high for 2 cycles.
- RTI immediately after that INT -> read at ...FFFE with rdata_dst=2, then read at ...FFFF with rdata_dst=1; sp_out=...FFFF.
- Enable=0 held 3 cycles during INT ACC1, plus Reset asserted in ACC2 of a second INT -> first: mem_we=0, SP frozen, then the ACC1 write is reissued; second: the cycle after Reset shows busy=0 and sp_out=32'h000F_FFFF.
- With STACK_BOUND_CHECK_EN, POP at SP=STACK_BASE -> fault=1 for one cycle, no mem_re, sp_out unchanged; INT at SP=32'h000F_F000 -> fault=1. Without the macro, the same POP yields a read at 32'h0010_0000 and sp_out=32'h0010_0000.
